coin_collector: RTL and testbench
=================================

Name: coin_collector

Overview:
- Front-end stage directly upstream of the vending core.
- Accepts single-coin NTD_10 pulses from the coin slot and accumulates them per transaction.
- Latches the buyer's item selection and presents one request (coin count + item type) to the core, held until the core is in SERVICE_ON.
- Handles cancel/timeout refunds. Keeps request lines at zero/ITEM_NONE at all other times, so the core never sees a spurious request.

Parameters:
- MAX_COINS, 3: saturation limit of the per-transaction coin count; must be ≤3 (2-bit core input).
- TIMEOUT_CYC, 255: idle cycles in COLLECT before an automatic refund; 8-bit timer.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- coin_pulse  input  1  one-cycle pulse = one NTD_10 coin inserted
- item_sel  input  2  item button; 2'b00 none, 2'b01 ITEM_A, others invalid
- cancel  input  1  one-cycle refund request
- core_ready  input  1  high when the core state is SERVICE_ON
- core_done  input  1  one-cycle pulse when the core state is SERVICE_OFF (change/item delivered)
- coinInNTD_10  output  2  coin count to the core; 0 unless the request is valid
- itemTypeIn  output  2  item to the core; ITEM_NONE unless the request is valid
- req_valid  output  1  request presented this cycle
- coin_reject  output  1  one-cycle pulse: the coin is physically returned
- refund_valid  output  1  one-cycle pulse: refund_count coins are returned
- refund_count  output  2  coins refunded; valid with refund_valid, else 0
- busy  output  1  high in REQUEST and WAIT_DONE

Behaviour:
- Reset (async, active-high), all registers cleared:
  - state=IDLE; count, timer, item_q = 0.
  - All outputs 0 (itemTypeIn=ITEM_NONE).
  - Reset mid-transaction discards accumulated coins; no refund pulse.
- All outputs are registered or decoded from registered state; no combinational path from any input to any output.
- IDLE:
  - coin_pulse -> count=1, timer=0, go COLLECT.
  - item_sel and cancel are ignored.
- COLLECT:
  - Each coin_pulse increments count.
  - At count==MAX_COINS a further coin does not increment; coin_reject pulses on the next cycle.
  - timer increments each cycle and clears on any coin_pulse.
  - Priority when events coincide, highest first:
    1. cancel -> REFUND.
    2. Valid item_sel (2'b01) -> item_q=item_sel, go REQUEST; a coin arriving the same cycle is included in count.
    3. timer==TIMEOUT_CYC-1 -> REFUND.
  - Invalid item_sel (2'b10/2'b11) is ignored.
- REQUEST:
  - req_valid=1, coinInNTD_10=count, itemTypeIn=item_q.
  - Transfer occurs on a clock edge with req_valid && core_ready; next state WAIT_DONE, and outputs return to 0 on the following cycle.
  - Held indefinitely while core_ready=0; cancel is ignored here.
  - Latency from item_sel to first req_valid: 1 cycle.
- WAIT_DONE:
  - Waits for core_done, then clears count and goes IDLE.
  - core_done outside WAIT_DONE is ignored.
- REFUND (one cycle):
  - refund_valid=1, refund_count=count.
  - Next cycle: IDLE with count=0.
- Coin rejection: any coin_pulse in REQUEST, WAIT_DONE or REFUND pulses coin_reject on the next cycle; count is unchanged.
- Arithmetic:
  - count is 2 bits, saturating, never wraps.
  - timer is 8 bits, saturating at TIMEOUT_CYC-1.

Decomposition:
- Shared package (vending_pkg): SERVICE_* codes, NTD_10 code, ITEM_NONE/ITEM_A codes, VALUE_NTD_10, COST_A.
- These are shared with the vending core, which includes the same definitions.
- FSM state encoding is local.
- One natural sub-module: coin_timeout_timer (8-bit saturating counter with clear/enable, terminal flag).

Test Plan:
- 2 coin pulses, then item_sel=01 with core_ready=1 -> req_valid 1 cycle later with coinInNTD_10=2, itemTypeIn=01; outputs 0 the next cycle; busy=1 until core_done.
- 4 coin pulses -> count saturates at 3; coin_reject pulses once, the cycle after the 4th coin; the subsequent request carries coinInNTD_10=3.
- 1 coin, item_sel=01 while core_ready=0 for 10 cycles -> req_valid, coinInNTD_10=1 held stable 10 cycles; transfer on the first core_ready=1 edge.
- 2 coins, then cancel and item_sel=01 in the same cycle -> refund_valid with refund_count=2, no req_valid, state IDLE next.
- 1 coin, no activity for 255 cycles -> refund_valid, refund_count=1; a coin inserted during WAIT_DONE -> coin_reject, count unchanged.
- Assert reset in REQUEST with count=2 -> all outputs 0 immediately (asynchronously); no refund; the next coin starts a fresh count=1.

Source files
------------

// File: rtl/coin_collector_pkg.sv
// coin_collector_pkg: codes shared with the vending core plus a saturating-increment helper.
//   SERVICE_*   core service state codes (core_ready reflects SERVICE_ON, core_done SERVICE_OFF)
//   item_t      item codes presented on itemTypeIn
//   NTD_10      coin denomination code, VALUE_NTD_10 its value, COST_A price of ITEM_A
package coin_collector_pkg;
  typedef enum logic [1:0] {
    SERVICE_OFF = 2'b00,
    SERVICE_ON  = 2'b01
  } service_t;
  typedef enum logic [1:0] {
    ITEM_NONE = 2'b00,
    ITEM_A    = 2'b01
  } item_t;
  localparam logic [1:0] NTD_10 = 2'b01;
  localparam int unsigned VALUE_NTD_10 = 10;
  localparam int unsigned COST_A = 20;
  function automatic logic [1:0] satInc(input logic [1:0] v, input logic [1:0] lim);
    return (v == lim) ? v : v + 2'd1;
  endfunction
endpackage

// File: rtl/coin_collector_if.sv
// coin_collector_if: coin-slot, buyer and vending-core signals around the coin collector.
//   master: drives slot/buyer/core status (coin_pulse, item_sel, cancel, core_ready, core_done)
//   slave:  the collector; drives the core request and the slot/refund feedback
interface coin_collector_if;
  logic       coin_pulse;
  logic [1:0] item_sel;
  logic       cancel;
  logic       core_ready;
  logic       core_done;
  logic [1:0] coinInNTD_10;
  logic [1:0] itemTypeIn;
  logic       req_valid;
  logic       coin_reject;
  logic       refund_valid;
  logic [1:0] refund_count;
  logic       busy;
  modport master (
    output coin_pulse, item_sel, cancel, core_ready, core_done,
    input  coinInNTD_10, itemTypeIn, req_valid, coin_reject, refund_valid, refund_count, busy
  );
  modport slave (
    input  coin_pulse, item_sel, cancel, core_ready, core_done,
    output coinInNTD_10, itemTypeIn, req_valid, coin_reject, refund_valid, refund_count, busy
  );
endinterface

// File: rtl/coin_collector_timer.sv
// coin_timeout_timer: 8-bit idle counter that saturates at TERMINAL and flags it.
//   clk, reset (async, active-high), clear (wins over enable), enable, terminal (value == TERMINAL)
module coin_timeout_timer #(
  parameter logic [7:0] TERMINAL = 8'd254
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);
  logic [7:0] value;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) value <= '0;
    else if (clear) value <= '0;
    else if (enable && value != TERMINAL) value <= value + 8'd1;
  end
  assign terminal = value == TERMINAL;
endmodule

// File: rtl/coin_collector.sv
// coin_collector: accumulates coins, latches the item and presents one request to the vending core.
//   clk, reset (async, active-high), bus (coin_collector_if.slave)
//   all bus outputs are registered or decoded from registered state only
module coin_collector
  import coin_collector_pkg::*;
#(
  parameter logic [1:0] MAX_COINS   = 2'd3,
  parameter logic [7:0] TIMEOUT_CYC = 8'd255
) (
  input logic             clk,
  input logic             reset,
  coin_collector_if.slave bus
);
  typedef enum logic [2:0] {IDLE, COLLECT, REQUEST, WAIT_DONE, REFUND} state_t;
  state_t     state, stateNext;
  logic [1:0] count, countNext;
  item_t      itemQ, itemNext;
  logic       coinReject, coinRejectNext;
  logic       timeout;
  logic       reqValid, refunding;
  coin_timeout_timer #(.TERMINAL(TIMEOUT_CYC - 8'd1)) timer (
    .clk(clk),
    .reset(reset),
    .clear(bus.coin_pulse || state != COLLECT),
    .enable(state == COLLECT),
    .terminal(timeout)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      itemQ      <= ITEM_NONE;
      coinReject <= 1'b0;
    end else begin
      state      <= stateNext;
      count      <= countNext;
      itemQ      <= itemNext;
      coinReject <= coinRejectNext;
    end
  end
  always_comb begin
    stateNext      = state;
    countNext      = count;
    itemNext       = itemQ;
    coinRejectNext = 1'b0;
    case (state)
      IDLE: begin
        if (bus.coin_pulse) begin
          countNext = 2'd1;
          stateNext = COLLECT;
        end
      end
      COLLECT: begin
        // a coin beyond MAX_COINS is still physically accepted by the slot but handed back
        countNext      = bus.coin_pulse ? satInc(count, MAX_COINS) : count;
        coinRejectNext = bus.coin_pulse && count == MAX_COINS;
        // a coin arriving on the terminal cycle restarts the idle period instead of refunding
        if (bus.cancel) stateNext = REFUND;
        else if (bus.item_sel == ITEM_A) begin
          itemNext  = ITEM_A;
          stateNext = REQUEST;
        end else if (timeout && !bus.coin_pulse) stateNext = REFUND;
      end
      REQUEST: begin
        coinRejectNext = bus.coin_pulse;
        if (bus.core_ready) stateNext = WAIT_DONE;
      end
      WAIT_DONE: begin
        coinRejectNext = bus.coin_pulse;
        if (bus.core_done) begin
          countNext = '0;
          itemNext  = ITEM_NONE;
          stateNext = IDLE;
        end
      end
      REFUND: begin
        coinRejectNext = bus.coin_pulse;
        countNext      = '0;
        itemNext       = ITEM_NONE;
        stateNext      = IDLE;
      end
      default: begin
        countNext = '0;
        itemNext  = ITEM_NONE;
        stateNext = IDLE;
      end
    endcase
  end
  assign reqValid         = state == REQUEST;
  assign refunding        = state == REFUND;
  assign bus.req_valid    = reqValid;
  assign bus.coinInNTD_10 = reqValid ? count : 2'd0;
  assign bus.itemTypeIn   = reqValid ? itemQ : ITEM_NONE;
  assign bus.refund_valid = refunding;
  assign bus.refund_count = refunding ? count : 2'd0;
  assign bus.busy         = reqValid || state == WAIT_DONE;
  assign bus.coin_reject  = coinReject;
endmodule

// File: tb/tb_coin_collector.sv
// tb_coin_collector: directed stimulus with a per-cycle behavioural model and literal spot checks.
module tb_coin_collector;
  localparam int MAX = 3;
  localparam int TO  = 255;
  logic clk = 1'b0;
  logic reset = 1'b1;
  coin_collector_if bus();
  coin_collector dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int errors = 0;
  int checks = 0;
  int mCoins, mIdle;
  bit mActive, mReq, mDeliver, mRefund, mReject;
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic modelReset();
    mCoins = 0; mIdle = 0; mActive = 0; mReq = 0; mDeliver = 0; mRefund = 0; mReject = 0;
  endtask
  task automatic modelStep(input bit coin, input int item, input bit cancel, input bit ready, input bit done);
    bit timedOut;
    mReject = 0;
    if (mRefund) begin
      mReject = coin; mRefund = 0; mCoins = 0; mActive = 0;
    end else if (mDeliver) begin
      mReject = coin;
      if (done) begin mDeliver = 0; mCoins = 0; mActive = 0; end
    end else if (mReq) begin
      mReject = coin;
      if (ready) begin mReq = 0; mDeliver = 1; end
    end else if (mActive) begin
      timedOut = (mIdle == TO - 1) && !coin;
      if (coin) begin
        if (mCoins == MAX) mReject = 1;
        else mCoins++;
      end
      mIdle = coin ? 0 : (mIdle < TO - 1 ? mIdle + 1 : mIdle);
      if (cancel) mRefund = 1;
      else if (item == 1) mReq = 1;
      else if (timedOut) mRefund = 1;
    end else if (coin) begin
      mActive = 1; mCoins = 1; mIdle = 0;
    end
  endtask
  task automatic compareAll();
    check("req_valid", int'(bus.req_valid), int'(mReq));
    check("coinInNTD_10", int'(bus.coinInNTD_10), mReq ? mCoins : 0);
    check("itemTypeIn", int'(bus.itemTypeIn), mReq ? 1 : 0);
    check("refund_valid", int'(bus.refund_valid), int'(mRefund));
    check("refund_count", int'(bus.refund_count), mRefund ? mCoins : 0);
    check("busy", int'(bus.busy), int'(mReq || mDeliver));
    check("coin_reject", int'(bus.coin_reject), int'(mReject));
  endtask
  task automatic cyc(input bit coin, input logic [1:0] item, input bit cancel, input bit ready, input bit done);
    bus.coin_pulse = coin;
    bus.item_sel   = item;
    bus.cancel     = cancel;
    bus.core_ready = ready;
    bus.core_done  = done;
    modelStep(coin, int'(item), cancel, ready, done);
    @(negedge clk);
    compareAll();
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.coin_pulse = 0; bus.item_sel = 0; bus.cancel = 0; bus.core_ready = 0; bus.core_done = 0;
    modelReset();
    repeat (2) @(negedge clk);
    compareAll();
    check("reset itemTypeIn", int'(bus.itemTypeIn), 0);
    reset = 1'b0;
    // two coins, select with core ready
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 0);
    check("t1 req_valid", int'(bus.req_valid), 1);
    check("t1 coins", int'(bus.coinInNTD_10), 2);
    check("t1 item", int'(bus.itemTypeIn), 1);
    cyc(0, 0, 0, 1, 0);
    check("t1 req dropped", int'(bus.req_valid), 0);
    check("t1 coins dropped", int'(bus.coinInNTD_10), 0);
    check("t1 busy", int'(bus.busy), 1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    check("t1 idle busy", int'(bus.busy), 0);
    // saturation, invalid select, stray core_done
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("t2 no reject at 3", int'(bus.coin_reject), 0);
    cyc(1, 0, 0, 0, 0);
    check("t2 reject 4th", int'(bus.coin_reject), 1);
    cyc(0, 2'b10, 0, 0, 1);
    check("t2 reject once", int'(bus.coin_reject), 0);
    check("t2 invalid item", int'(bus.req_valid), 0);
    cyc(0, 2'b11, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    check("t2 saturated coins", int'(bus.coinInNTD_10), 3);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1);
    // held request while core not ready; coin and cancel rejected/ignored in REQUEST
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      check("t3 held req", int'(bus.req_valid), 1);
      check("t3 held coins", int'(bus.coinInNTD_10), 1);
      cyc(0, 0, i == 3, 0, 0);
    end
    check("t3 held req 10", int'(bus.coinInNTD_10), 1);
    cyc(1, 0, 0, 0, 0);
    check("t3 reject in request", int'(bus.coin_reject), 1);
    check("t3 count unchanged", int'(bus.coinInNTD_10), 1);
    cyc(0, 0, 0, 1, 0);
    check("t3 transfer", int'(bus.req_valid), 0);
    cyc(0, 0, 0, 0, 1);
    // cancel beats item_sel
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 0);
    check("t4 refund_valid", int'(bus.refund_valid), 1);
    check("t4 refund_count", int'(bus.refund_count), 2);
    check("t4 no req", int'(bus.req_valid), 0);
    cyc(0, 0, 0, 0, 0);
    check("t4 refund over", int'(bus.refund_valid), 0);
    check("t4 refund_count zero", int'(bus.refund_count), 0);
    // timeout refund
    cyc(1, 0, 0, 0, 0);
    repeat (254) cyc(0, 0, 0, 0, 0);
    check("t5 no early refund", int'(bus.refund_valid), 0);
    cyc(0, 0, 0, 0, 0);
    check("t5 timeout refund", int'(bus.refund_valid), 1);
    check("t5 timeout count", int'(bus.refund_count), 1);
    cyc(1, 0, 0, 0, 0);
    check("t5 reject in refund", int'(bus.coin_reject), 1);
    cyc(0, 0, 0, 0, 0);
    // coin during WAIT_DONE
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0);
    check("t5 reject in wait", int'(bus.coin_reject), 1);
    check("t5 busy in wait", int'(bus.busy), 1);
    cyc(0, 0, 0, 0, 1);
    // async reset while requesting
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    check("t6 pre-reset coins", int'(bus.coinInNTD_10), 2);
    #3 reset = 1'b1;
    #1;
    modelReset();
    compareAll();
    check("t6 async req", int'(bus.req_valid), 0);
    check("t6 async busy", int'(bus.busy), 0);
    @(negedge clk);
    compareAll();
    reset = 1'b0;
    cyc(1, 0, 0, 0, 0);
    check("t6 no refund", int'(bus.refund_valid), 0);
    cyc(0, 1, 0, 0, 0);
    check("t6 fresh count", int'(bus.coinInNTD_10), 1);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
